// File: rtl/rf_pkg.sv
// Shared defaults for the register file with scoreboard.
// Data width, register count and address width are defined once here.
package rf_pkg;
  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;
  localparam int RF_AW   = $clog2(RF_NREG);
endpackage

// File: rtl/rf_read_port.sv
// One combinational read path: register mux, write-through bypass and busy masking.
// Register 0 always reads as zero and never busy.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic [AW-1:0]   rd_addr_i,
  input  logic [XLEN-1:0] regs_i [NREG],
  input  logic [NREG-1:0] busy_i,
  input  logic            byp_en_i,
  input  logic [AW-1:0]   byp_addr_i,
  input  logic [XLEN-1:0] byp_data_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            busy_o
);

  logic byp_hit;

  assign byp_hit = byp_en_i && (byp_addr_i == rd_addr_i);

  always_comb begin
    rdata_o = regs_i[rd_addr_i];
    busy_o  = busy_i[rd_addr_i];
    if (rd_addr_i == '0) begin
      rdata_o = '0;
      busy_o  = 1'b0;
    end else if (byp_hit) begin
      // The producer is writing back right now, so the value is already valid.
      rdata_o = byp_data_i;
      busy_o  = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard and a running busy count.
// Two read ports with same-cycle writeback bypass; x0 is hardwired to zero.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            regWrite,
  input  logic [AW-1:0]   writeAddr,
  input  logic [XLEN-1:0] writeData,
  input  logic            issue,
  input  logic [AW-1:0]   issue_addr,
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     busy_cnt_q, busy_cnt_d;
  logic            wr_hit, iss_hit, cnt_inc, cnt_dec, byp_en;

  assign wr_hit  = regWrite && (writeAddr != '0);
  assign iss_hit = issue && (issue_addr != '0);
  // Bypass is gated by reset so the read ports show zero while reset is held.
  assign byp_en  = regWrite && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[writeAddr] <= writeData;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_hit)  busy_d[writeAddr]  = 1'b0;
      if (iss_hit) busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Count only real transitions: re-issuing a busy register or retiring an idle one is a no-op.
  always_comb begin
    cnt_inc    = iss_hit && !flush && !busy_q[issue_addr];
    cnt_dec    = wr_hit && !flush && busy_q[writeAddr] &&
                 !(iss_hit && (issue_addr == writeAddr));
    busy_cnt_d = busy_cnt_q;
    if (flush) begin
      busy_cnt_d = '0;
    end else begin
      busy_cnt_d = busy_cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  rf_read_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rd1 (
    .rd_addr_i  (rd_addr1),
    .regs_i     (regs_q),
    .busy_i     (busy_q),
    .byp_en_i   (byp_en),
    .byp_addr_i (writeAddr),
    .byp_data_i (writeData),
    .rdata_o    (rs1),
    .busy_o     (rs1_busy)
  );

  rf_read_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rd2 (
    .rd_addr_i  (rd_addr2),
    .regs_i     (regs_q),
    .busy_i     (busy_q),
    .byp_en_i   (byp_en),
    .byp_addr_i (writeAddr),
    .byp_data_i (writeData),
    .rdata_o    (rs2),
    .busy_o     (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against an array/popcount model.
module tb_regfile_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rd_addr1, rd_addr2, writeAddr, issue_addr;
  logic [XLEN-1:0] rs1, rs2, writeData;
  logic            rs1_busy, rs2_busy, regWrite, issue, flush;
  logic [AW:0]     busy_cnt;

  int nvec = 0;
  int nerr = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .regWrite   (regWrite),
    .writeAddr  (writeAddr),
    .writeData  (writeData),
    .issue      (issue),
    .issue_addr (issue_addr),
    .flush      (flush),
    .busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [XLEN-1:0] m_rs(input int a);
    if (a == 0) return '0;
    if (regWrite && int'(writeAddr) == a) return writeData;
    return m_regs[a];
  endfunction

  function automatic logic m_rbusy(input int a);
    if (a == 0) return 1'b0;
    if (regWrite && int'(writeAddr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    #1;
    check({tag, ".rs1"},   rs1,                    m_rs(int'(rd_addr1)));
    check({tag, ".rs2"},   rs2,                    m_rs(int'(rd_addr2)));
    check({tag, ".busy1"}, XLEN'(rs1_busy),        XLEN'(m_rbusy(int'(rd_addr1))));
    check({tag, ".busy2"}, XLEN'(rs2_busy),        XLEN'(m_rbusy(int'(rd_addr2))));
    check({tag, ".cnt"},   XLEN'(busy_cnt),        XLEN'(m_count()));
  endtask

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (regWrite && writeAddr != 0) m_regs[writeAddr] = writeData;
    if (flush) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else begin
      if (regWrite && writeAddr != 0) m_busy[writeAddr] = 1'b0;
      if (issue && issue_addr != 0)   m_busy[issue_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    regWrite = 0; writeAddr = '0; writeData = '0;
    issue = 0; issue_addr = '0; flush = 0;
  endtask

  initial begin
    rst = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0;
    idle_inputs();
    model_reset();
    #12;
    check_outputs("in_reset");
    #5 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NREG; i++) begin
      rd_addr1 = AW'(i);
      rd_addr2 = AW'(NREG - 1 - i);
      #1;
      check("post_rst.rs1",  rs1, '0);
      check("post_rst.b1",   XLEN'(rs1_busy), '0);
      check("post_rst.cnt",  XLEN'(busy_cnt), '0);
      check_outputs("post_rst");
    end

    // Write-through bypass to x5, then held value.
    rd_addr1 = 5; rd_addr2 = 6;
    regWrite = 1; writeAddr = 5; writeData = 32'hDEADBEEF;
    #1 check("byp_x5", rs1, 32'hDEADBEEF);
    check_outputs("byp_x5");
    tick();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      #1 check("hold_x5", rs1, 32'hDEADBEEF);
      check_outputs("hold_x5");
      tick();
    end

    // Issue x7, then writeback + reissue on the same edge.
    rd_addr1 = 7;
    issue = 1; issue_addr = 7;
    tick();
    idle_inputs();
    #1 check("iss7.busy", XLEN'(rs1_busy), 1);
    check("iss7.cnt", XLEN'(busy_cnt), 1);
    regWrite = 1; writeAddr = 7; writeData = 32'h0000_0077;
    issue = 1; issue_addr = 7;
    check_outputs("wr_iss7");
    tick();
    idle_inputs();
    #1 check("reiss7.busy", XLEN'(rs1_busy), 1);
    check("reiss7.cnt", XLEN'(busy_cnt), 1);
    check("reiss7.data", rs1, 32'h0000_0077);

    // Writes and issues to x0 are ignored.
    rd_addr1 = 0;
    regWrite = 1; writeAddr = 0; writeData = 32'h1234;
    issue = 1; issue_addr = 0;
    #1 check("x0.rs1_same", rs1, '0);
    tick();
    idle_inputs();
    #1 check("x0.rs1", rs1, '0);
    check("x0.busy", XLEN'(rs1_busy), 0);
    check("x0.cnt", XLEN'(busy_cnt), 1);

    // Flush wins over a same-cycle issue.
    for (int a = 1; a <= 3; a++) begin
      issue = 1; issue_addr = AW'(a);
      tick();
    end
    idle_inputs();
    #1 check("pre_flush.cnt", XLEN'(busy_cnt), 4);
    flush = 1; issue = 1; issue_addr = 4;
    tick();
    idle_inputs();
    rd_addr1 = 4; rd_addr2 = 1;
    #1 check("flush.cnt", XLEN'(busy_cnt), 0);
    check("flush.x4busy", XLEN'(rs1_busy), 0);
    check_outputs("flush");

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rd_addr1   = AW'($urandom_range(0, NREG - 1));
      rd_addr2   = ($urandom_range(0, 3) == 0) ? writeAddr : AW'($urandom_range(0, NREG - 1));
      regWrite   = ($urandom_range(0, 1) == 1);
      writeAddr  = AW'($urandom_range(0, NREG - 1));
      writeData  = $urandom;
      issue      = ($urandom_range(0, 2) != 0);
      issue_addr = ($urandom_range(0, 5) == 0) ? writeAddr : AW'($urandom_range(0, NREG - 1));
      flush      = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) == 0) rd_addr2 = writeAddr;
      check_outputs("rand");
      tick();
    end

    // Mid-cycle asynchronous reset with a writeback presented.
    idle_inputs();
    rd_addr1 = 9; rd_addr2 = 9;
    regWrite = 1; writeAddr = 9; writeData = 32'hCAFE_F00D;
    tick();
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("arst.rs1",  rs1, '0);
    check("arst.rs2",  rs2, '0);
    check("arst.b1",   XLEN'(rs1_busy), 0);
    check("arst.b2",   XLEN'(rs2_busy), 0);
    check("arst.cnt",  XLEN'(busy_cnt), 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs("resume");

    for (int n = 0; n < 100; n++) begin
      rd_addr1   = AW'($urandom_range(0, NREG - 1));
      rd_addr2   = AW'($urandom_range(0, NREG - 1));
      regWrite   = ($urandom_range(0, 1) == 1);
      writeAddr  = AW'($urandom_range(0, NREG - 1));
      writeData  = $urandom;
      issue      = ($urandom_range(0, 1) == 1);
      issue_addr = AW'($urandom_range(0, NREG - 1));
      flush      = ($urandom_range(0, 31) == 0);
      check_outputs("rand2");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of each register.
REQ-002 SHALL have parameter NREG, default 32: register count; power of two, at least 4.
REQ-003 SHALL have parameter AW, default $clog2(NREG): register address width.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports rd_addr1 and rd_addr2  in  AW  read port addresses.
REQ-007 SHALL have ports rs1 and rs2  out  XLEN  read data for rd_addr1 and rd_addr2.
REQ-008 SHALL have ports rs1_busy and rs2_busy  out  1  a pending write exists for the addressed register.
REQ-009 SHALL have port regWrite  in  1  writeback enable.
REQ-010 SHALL have port writeAddr  in  AW  writeback address.
REQ-011 SHALL have port writeData  in  XLEN  writeback data.
REQ-012 SHALL have port issue  in  1  marks issue_addr as pending (busy).
REQ-013 SHALL have port issue_addr  in  AW  destination register of the issuing instruction.
REQ-014 SHALL have port flush  in  1  clears all busy bits.
REQ-015 SHALL have port busy_cnt  out  AW+1  number of registers currently busy.

Function
REQ-016 SHALL hardwire register 0 to zero: reads return 0, busy reads 0, and writes and issues to address 0 are ignored.
REQ-017 SHALL on a rising edge with regWrite=1 and writeAddr!=0 store writeData into register writeAddr.
REQ-018 SHALL make reads combinational; when regWrite=1 and writeAddr==rd_addrN (nonzero), rsN SHALL equal writeData in that same cycle (write-through bypass).
REQ-019 SHALL make rsN_busy combinational: busy[rd_addrN], forced to 0 when a bypassing writeback to that address is present in the same cycle.
REQ-020 SHALL set busy[issue_addr] on the edge where issue=1 and issue_addr!=0.
REQ-021 SHALL clear busy[writeAddr] on the edge where regWrite=1, unless an issue to the same address occurs on that edge; in that case busy SHALL end up 1 (the newer producer wins).
REQ-022 SHALL accept a writeback to a non-busy register: data is written and busy stays 0.
REQ-023 SHALL on an edge with flush=1 clear every busy bit, ignore a same-cycle issue, and still perform a same-cycle regWrite data write.
REQ-024 SHALL keep busy_cnt registered and equal to the number of set busy bits after each edge, with a range of 0..NREG-1.
REQ-025 SHALL update busy_cnt by +1, -1 or 0 per edge; issuing to an already-busy register SHALL NOT increment it.

Reset
REQ-026 SHALL while rst=0, asynchronously clear all registers to 0, all busy bits to 0, and busy_cnt to 0.
REQ-027 SHALL drive rs1 and rs2 to 0 and rs1_busy, rs2_busy and busy_cnt to 0 during reset; any issue or write in progress is discarded.
REQ-028 SHALL resume normal operation on the first rising edge after rst returns to 1.

Structure
REQ-029 SHALL put XLEN, NREG and AW defaults in shared package rf_pkg.
REQ-030 SHALL implement each read path (mux, bypass, busy masking) in one sub-module, rf_read_port, instantiated twice.
REQ-031 SHALL keep the register array, busy vector and busy_cnt counter in the top module.

Verification
REQ-032 SHALL verify: after reset, read addresses 0..31 -> all rs=0, busy=0, busy_cnt=0.
REQ-033 SHALL verify: regWrite to x5 with 0xDEADBEEF while rd_addr1=5 -> rs1=0xDEADBEEF in the same cycle, and held on the following cycles.
REQ-034 SHALL verify: issue to x7 -> next cycle rs1_busy=1 and busy_cnt=1; then regWrite to x7 with issue to x7 on the same edge -> busy stays 1 and busy_cnt=1.
REQ-035 SHALL verify: regWrite to x0 with 0x1234 and issue to x0 -> rs1=0, busy=0, busy_cnt unchanged.
REQ-036 SHALL verify: issue to x1, x2 and x3, then flush together with an issue to x4 -> busy_cnt=0 and x4 not busy.
REQ-037 SHALL verify: rst asserted mid-cycle after writes -> all outputs 0 immediately, without waiting for a clock edge.
